// File: rtl/key_entry_buffer_pkg.sv
// Shared keypad codes, display width and BCD helpers for the key entry buffer.
package key_entry_buffer_pkg;

    localparam logic [3:0]  KEY_BKSP    = 4'hA;
    localparam logic [3:0]  KEY_CLEAR   = 4'hB;
    localparam logic [3:0]  KEY_ENTER   = 4'hC;
    localparam int unsigned DISP_DIGITS = 4;

    typedef enum logic [2:0] {
        KC_DIGIT,
        KC_BKSP,
        KC_CLEAR,
        KC_ENTER,
        KC_NONE
    } key_class_e;

    function automatic key_class_e classify_key(input logic [3:0] code);
        if (code <= 4'd9)
            return KC_DIGIT;
        else if (code == KEY_BKSP)
            return KC_BKSP;
        else if (code == KEY_CLEAR)
            return KC_CLEAR;
        else if (code == KEY_ENTER)
            return KC_ENTER;
        else
            return KC_NONE;
    endfunction

    // Four packed BCD digits to binary; at most 9999, so 14 bits suffice.
    function automatic logic [13:0] bcd_to_bin(input logic [15:0] b);
        return 14'(b[15:12]) * 14'd1000 + 14'(b[11:8]) * 14'd100
             + 14'(b[7:4]) * 14'd10 + 14'(b[3:0]);
    endfunction

endpackage

// File: rtl/key_entry_buffer_sync.sv
// Two-flop synchronizer, rising-edge detect and holdoff re-arm for the keypad level.
module key_edge_sync #(
    parameter int unsigned HOLDOFF = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       level_in,
    input  logic [3:0] code_in,
    output logic       strobe,
    output logic [3:0] code_out
);

    localparam int unsigned CW = $clog2(HOLDOFF + 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_s3;
    logic          r_armed;
    logic [3:0]    r_code;
    logic [3:0]    r_code_out;
    logic          r_strobe;
    logic [CW-1:0] r_cnt;
    logic          w_rise;

    assign w_rise   = r_s2 & ~r_s3;
    assign strobe   = r_strobe;
    assign code_out = r_code_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_s3       <= 1'b0;
            r_armed    <= 1'b1;
            r_code     <= '0;
            r_code_out <= '0;
            r_strobe   <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_s1     <= level_in;
            r_s2     <= r_s1;
            r_s3     <= r_s2;
            r_code   <= code_in;
            r_strobe <= 1'b0;
            if (r_armed) begin
                if (w_rise) begin
                    r_strobe   <= 1'b1;
                    r_code_out <= r_code;
                    r_armed    <= 1'b0;
                    r_cnt      <= '0;
                end
            // Re-arm only after HOLDOFF unbroken low samples; any high sample restarts.
            end else if (r_s2) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(HOLDOFF - 1)) begin
                r_armed <= 1'b1;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_entry_buffer.sv
// Decimal entry register: shifts keypad digits in, supports backspace/clear/enter,
// and publishes the entered value in binary with a one-cycle valid pulse.
module key_entry_buffer
    import key_entry_buffer_pkg::*;
#(
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned HOLDOFF = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  key_num,
    input  logic        key_pressed,
    output logic [15:0] bcd,
    output logic [3:0]  blank,
    output logic [2:0]  dig_count,
    output logic        overflow,
    output logic [13:0] value,
    output logic        value_valid
);

    localparam logic [2:0] FULL = 3'(DIGITS);

    logic        w_strobe;
    logic [3:0]  w_code;
    logic [3:0]  w_blank;
    logic [15:0] r_bcd;
    logic [2:0]  r_cnt;
    logic        r_ovf;
    logic [13:0] r_value;
    logic        r_vv;

    key_edge_sync #(
        .HOLDOFF(HOLDOFF)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .level_in(key_pressed),
        .code_in (key_num),
        .strobe  (w_strobe),
        .code_out(w_code)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_value <= '0;
            r_vv    <= 1'b0;
        end else begin
            r_vv <= 1'b0;
            if (w_strobe) begin
                case (classify_key(w_code))
                    KC_DIGIT: begin
                        if (r_cnt < FULL) begin
                            r_bcd <= {r_bcd[11:0], w_code};
                            r_cnt <= r_cnt + 3'd1;
                        end else begin
                            r_ovf <= 1'b1;
                        end
                    end
                    KC_BKSP: begin
                        if (r_cnt != 3'd0) begin
                            r_bcd <= {4'h0, r_bcd[15:4]};
                            r_cnt <= r_cnt - 3'd1;
                            r_ovf <= 1'b0;
                        end
                    end
                    KC_CLEAR: begin
                        r_bcd <= '0;
                        r_cnt <= '0;
                        r_ovf <= 1'b0;
                    end
                    KC_ENTER: begin
                        if (r_cnt != 3'd0) begin
                            r_value <= bcd_to_bin(r_bcd);
                            r_vv    <= 1'b1;
                            r_bcd   <= '0;
                            r_cnt   <= '0;
                            r_ovf   <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Digit 0 is never blanked so an empty entry still shows "0".
    always_comb begin
        w_blank = '0;
        for (int unsigned i = 1; i < DISP_DIGITS; i++)
            w_blank[i] = (i >= 32'(r_cnt));
    end

    assign bcd         = r_bcd;
    assign blank       = w_blank;
    assign dig_count   = r_cnt;
    assign overflow    = r_ovf;
    assign value       = r_value;
    assign value_valid = r_vv;

endmodule

// File: tb/tb_key_entry_buffer.sv
// Directed bench for key_entry_buffer: state checks after each key, ENTER results via scoreboard.
module tb_key_entry_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  key_num = '0;
    logic        key_pressed = 1'b0;
    logic [15:0] bcd;
    logic [3:0]  blank;
    logic [2:0]  dig_count;
    logic        overflow;
    logic [13:0] value;
    logic        value_valid;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    typedef struct {
        int unsigned val;
        int          cyc;
    } exp_t;
    exp_t q[$];

    logic [3:0] blank_for [5] = '{4'b1110, 4'b1110, 4'b1100, 4'b1000, 4'b0000};

    key_entry_buffer #(
        .DIGITS (4),
        .HOLDOFF(4)
    ) dut (
        .clk        (clk),
        .reset      (rst),
        .key_num    (key_num),
        .key_pressed(key_pressed),
        .bcd        (bcd),
        .blank      (blank),
        .dig_count  (dig_count),
        .overflow   (overflow),
        .value      (value),
        .value_valid(value_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [15:0] eb, input int ec, input logic eo);
        check({tag, ".bcd"}, bcd, eb);
        check({tag, ".count"}, 16'(dig_count), 16'(ec));
        check({tag, ".blank"}, 16'(blank), 16'(blank_for[ec]));
        check({tag, ".ovf"}, 16'(overflow), 16'(eo));
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic press(input logic [3:0] k, input int hold, input int rel);
        key_num     = k;
        key_pressed = 1'b1;
        repeat (hold) @(negedge clk);
        key_pressed = 1'b0;
        repeat (rel) @(negedge clk);
    endtask

    task automatic key(input logic [3:0] k);
        press(k, 4, 8);
    endtask

    task automatic enter(input int unsigned expv, input bit timed);
        q.push_back('{expv, timed ? cyc + 4 : -1});
        key(4'hC);
    endtask

    // Scoreboard monitor: every value_valid pulse must match the oldest expected ENTER.
    logic prev_vv = 1'b0;
    always @(negedge clk) begin
        if (!rst && value_valid) begin
            tests++;
            if (prev_vv) begin
                failed++;
                $display("FAIL vv_width: got 2 consecutive cycles expected 1");
            end
            if (q.size() == 0) begin
                failed++;
                $display("FAIL vv_spurious: got pulse value=%0d expected none", value);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (value !== 14'(e.val)) begin
                    failed++;
                    $display("FAIL value: got %0d expected %0d", value, e.val);
                end
                if (e.cyc >= 0 && cyc != e.cyc) begin
                    failed++;
                    $display("FAIL vv_latency: got cycle %0d expected %0d", cyc, e.cyc);
                end
            end
        end
        prev_vv <= value_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] mb;
        int unsigned mv;
        int          mc;
        logic [3:0]  k;

        repeat (3) @(negedge clk);
        chk_state("reset", 16'h0000, 0, 1'b0);
        check("reset.value", 16'(value), 16'd0);
        check("reset.vv", 16'(value_valid), 16'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: reset mid-entry, then immediate accept
        key(4'd1);
        key_num = 4'd2; key_pressed = 1'b1;
        repeat (5) @(negedge clk);
        chk_state("t1.pre", 16'h0012, 2, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk_state("t1.rst", 16'h0000, 0, 1'b0);
        check("t1.rst.value", 16'(value), 16'd0);
        key_pressed = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        press(4'd7, 4, 1);
        chk_state("t1.new", 16'h0007, 1, 1'b0);
        repeat (8) @(negedge clk);
        key(4'hB);
        chk_state("t1.clr", 16'h0000, 0, 1'b0);

        // 2: fill, overflow, backspace
        key(4'd1); key(4'd2); key(4'd3);
        chk_state("t2.3", 16'h0123, 3, 1'b0);
        key(4'd4);
        chk_state("t2.4", 16'h1234, 4, 1'b0);
        key(4'd5);
        chk_state("t2.ovf", 16'h1234, 4, 1'b1);
        key(4'hA);
        chk_state("t2.bksp", 16'h0123, 3, 1'b0);
        key(4'hB);
        chk_state("t2.clr", 16'h0000, 0, 1'b0);

        // 3: 9,0,7 ENTER
        key(4'd9); key(4'd0); key(4'd7);
        chk_state("t3.pre", 16'h0907, 3, 1'b0);
        enter(907, 1'b1);
        chk_state("t3.post", 16'h0000, 0, 1'b0);
        check("t3.value", 16'(value), 16'd907);

        // 4: no-ops on empty buffer
        key(4'hC); key(4'hA); key(4'hE);
        chk_state("t4", 16'h0000, 0, 1'b0);
        check("t4.value", 16'(value), 16'd907);

        // full buffer with overflow, then ENTER clears overflow
        key(4'd9); key(4'd9); key(4'd9); key(4'd9); key(4'd3);
        chk_state("t4b.ovf", 16'h9999, 4, 1'b1);
        enter(9999, 1'b1);
        chk_state("t4b.post", 16'h0000, 0, 1'b0);

        // 5: held key, short release, re-press dropped
        press(4'd5, 100, 2);
        press(4'd6, 6, 8);
        chk_state("t5.drop", 16'h0005, 1, 1'b0);
        key(4'd6);
        chk_state("t5.accept", 16'h0056, 2, 1'b0);
        key(4'hB);

        // 6: random phase presses
        for (int r = 0; r < 2; r++) begin
            mb = '0; mv = 0; mc = 0;
            for (int d = 0; d < 3 + r; d++) begin
                k = 4'($urandom_range(0, 9));
                #($urandom_range(0, 9));
                key_num = k; key_pressed = 1'b1;
                #($urandom_range(45, 120));
                key_pressed = 1'b0;
                #($urandom_range(100, 160));
                @(negedge clk);
                mb = {mb[11:0], k}; mv = mv * 10 + k; mc++;
                chk_state("t6.digit", mb, mc, 1'b0);
            end
            enter(mv, 1'b1);
            chk_state("t6.post", 16'h0000, 0, 1'b0);
        end

        repeat (20) @(negedge clk);
        check("pending_enters", 16'(q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
